// File: rtl/zbuf_pkg.sv
// ============================================================================
// Module   : zbuf_pkg
// Purpose  : Shared types and helpers for the z-buffer line responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package zbuf_pkg;

  localparam int COORD_W = 8;
  localparam int POINT_W = 3 * COORD_W;
  localparam int ERR_W   = COORD_W + 2;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } point_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    STEP = 2'd2
  } lr_state_t;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

`default_nettype wire

// File: rtl/udiv_serial.sv
// ============================================================================
// Module   : udiv_serial
// Purpose  : Restoring unsigned divider, one quotient bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module udiv_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int               CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_ITER = CNT_W'(WIDTH);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   w_shift;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    w_shift = {rem_q, quo_q[WIDTH-1]};
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = C_ITER;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      // Partial remainder stays below the divisor, so the low bits hold the difference.
      if (w_shift >= {1'b0, dvs_q}) begin
        rem_d = w_shift[WIDTH-1:0] - dvs_q;
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = w_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign done      = (cnt_q == CNT_W'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

`default_nettype wire

// File: rtl/line_responder.sv
// ============================================================================
// Module   : line_responder
// Purpose  : Accepts one edge, walks it with Bresenham in x/y and exact z.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_responder
  import zbuf_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_line,
  output logic               ack_line,
  input  logic [POINT_W-1:0] point_start,
  input  logic [POINT_W-1:0] point_end,
  output logic [POINT_W-1:0] point_out,
  output logic               valid_out,
  input  logic               ready_in,
  output logic               eoc,
  output logic               busy
);

  point_t             s_pt, e_pt, cur_q, cur_d;
  lr_state_t          state_q, state_d;
  logic [COORD_W-1:0] dx_q, dx_d, dy_q, dy_d, major_q, major_d;
  logic [COORD_W-1:0] cnt_q, cnt_d, zerr_q, zerr_d;
  logic               sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
  logic               ack_q, ack_d, valid_q, valid_d;
  logic signed [ERR_W-1:0] err_q, err_d;

  logic [COORD_W-1:0] w_dx, w_dy, w_dz, w_major, w_quo, w_rem, w_zstep;
  logic               w_div_start, w_div_done, w_last, w_zcarry;
  logic signed [ERR_W:0] w_e2, w_dx_s, w_dy_s;
  logic [COORD_W:0]   w_zsum;

  assign s_pt    = point_start;
  assign e_pt    = point_end;
  assign w_dx    = abs_diff(s_pt.x, e_pt.x);
  assign w_dy    = abs_diff(s_pt.y, e_pt.y);
  assign w_dz    = abs_diff(s_pt.z, e_pt.z);
  assign w_major = (w_dx >= w_dy) ? w_dx : w_dy;

  // Divider is launched straight from the request so DIV lasts exactly COORD_W cycles.
  assign w_div_start = (state_q == IDLE) && req_line && (w_major != '0);

  udiv_serial #(.WIDTH(COORD_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (w_div_start),
    .dividend  (w_dz),
    .divisor   (w_major),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  assign w_last   = (cnt_q == major_q);
  assign w_e2     = {err_q, 1'b0};
  assign w_dx_s   = {{(ERR_W + 1 - COORD_W){1'b0}}, dx_q};
  assign w_dy_s   = {{(ERR_W + 1 - COORD_W){1'b0}}, dy_q};
  assign w_zsum   = {1'b0, zerr_q} + {1'b0, w_rem};
  assign w_zcarry = (w_zsum >= {1'b0, major_q});
  assign w_zstep  = w_quo + {{(COORD_W - 1){1'b0}}, w_zcarry};

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    major_d = major_q;
    cnt_d   = cnt_q;
    zerr_d  = zerr_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    sz_d    = sz_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_line) begin
          cur_d   = s_pt;
          dx_d    = w_dx;
          dy_d    = w_dy;
          major_d = w_major;
          sx_d    = (e_pt.x < s_pt.x);
          sy_d    = (e_pt.y < s_pt.y);
          sz_d    = (e_pt.z < s_pt.z);
          err_d   = $signed({2'b00, w_dx}) - $signed({2'b00, w_dy});
          cnt_d   = '0;
          zerr_d  = '0;
          ack_d   = 1'b1;
          state_d = (w_major != '0) ? DIV : STEP;
        end
      end
      DIV: begin
        if (w_div_done) state_d = STEP;
      end
      STEP: begin
        valid_d = 1'b1;
        if (valid_q && ready_in) begin
          if (w_last) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + COORD_W'(1);
            if (w_e2 > -w_dy_s) begin
              err_d   = err_d - $signed({2'b00, dy_q});
              cur_d.x = sx_q ? cur_q.x - COORD_W'(1) : cur_q.x + COORD_W'(1);
            end
            if (w_e2 < w_dx_s) begin
              err_d   = err_d + $signed({2'b00, dx_q});
              cur_d.y = sy_q ? cur_q.y - COORD_W'(1) : cur_q.y + COORD_W'(1);
            end
            zerr_d  = w_zcarry ? (w_zsum[COORD_W-1:0] - major_q) : w_zsum[COORD_W-1:0];
            cur_d.z = sz_q ? cur_q.z - w_zstep : cur_q.z + w_zstep;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      major_q <= '0;
      cnt_q   <= '0;
      zerr_q  <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      sz_q    <= 1'b0;
      err_q   <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      major_q <= major_d;
      cnt_q   <= cnt_d;
      zerr_q  <= zerr_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      sz_q    <= sz_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
    end
  end

  assign ack_line  = ack_q;
  assign point_out = cur_q;
  assign valid_out = valid_q;
  assign eoc       = valid_q && w_last;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_line_responder.sv
// ============================================================================
// Module   : tb_line_responder
// Purpose  : Self-checking bench for line_responder (vectors + random lines).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_line_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_line;
  logic        ack_line;
  logic [23:0] point_start;
  logic [23:0] point_end;
  logic [23:0] point_out;
  logic        valid_out;
  logic        ready_in;
  logic        eoc;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];
  logic [23:0] ref_q[$];

  typedef struct {
    logic [23:0] ps;
    logic [23:0] pe;
    int          mode;
    bit          poke;
    int          exp_n;
    logic [23:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  line_responder dut (
    .clk         (clk),
    .rst         (rst),
    .req_line    (req_line),
    .ack_line    (ack_line),
    .point_start (point_start),
    .point_end   (point_end),
    .point_out   (point_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .eoc         (eoc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: Bresenham for x/y, z as the exact floor of dz*k/major.
  task automatic build_model(input logic [23:0] ps, input logic [23:0] pe);
    int x0, y0, z0, x1, y1, z1, dx, dy, dz, sx, sy, sz, major, err, e2, x, y, z;
    x0 = int'(ps[23:16]); y0 = int'(ps[15:8]); z0 = int'(ps[7:0]);
    x1 = int'(pe[23:16]); y1 = int'(pe[15:8]); z1 = int'(pe[7:0]);
    dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy = (y1 > y0) ? y1 - y0 : y0 - y1;
    dz = (z1 > z0) ? z1 - z0 : z0 - z1;
    sx = (x1 >= x0) ? 1 : -1;
    sy = (y1 >= y0) ? 1 : -1;
    sz = (z1 >= z0) ? 1 : -1;
    major = (dx > dy) ? dx : dy;
    err = dx - dy;
    x = x0;
    y = y0;
    exp_q.delete();
    for (int k = 0; k <= major; k++) begin
      z = (major == 0) ? z0 : z0 + sz * ((dz * k) / major);
      exp_q.push_back({8'(x), 8'(y), 8'(z)});
      e2 = 2 * err;
      if (e2 > -dy) begin err = err - dy; x = x + sx; end
      if (e2 < dx)  begin err = err + dx; y = y + sy; end
    end
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic run_line(input string tag, input logic [23:0] ps, input logic [23:0] pe,
                          input int mode, input bit poke);
    int          lat, idx, cyc, exp_lat;
    bit          held, fin;
    logic [23:0] hold_pt;
    logic        hold_eoc;
    build_model(ps, pe);
    got_q.delete();
    exp_lat = (exp_q.size() == 1) ? 1 : 9;
    point_start = ps;
    point_end   = pe;
    req_line    = 1'b1;
    @(posedge clk); #1;
    chk({tag, " ack"}, 32'(ack_line), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " valid at T"}, 32'(valid_out), 32'd0);
    req_line    = 1'b0;
    point_start = 24'($urandom);
    point_end   = 24'($urandom);
    lat = 0;
    while (!valid_out && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) chk({tag, " ack pulse"}, 32'(ack_line), 32'd0);
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    idx = 0; cyc = 0; held = 1'b0; fin = 1'b0;
    hold_pt = '0; hold_eoc = 1'b0;
    while (!fin && cyc < 3000) begin
      if (held) begin
        chk({tag, " hold point"}, 32'(point_out), 32'(hold_pt));
        chk({tag, " hold eoc"}, 32'(eoc), 32'(hold_eoc));
        chk({tag, " hold valid"}, 32'(valid_out), 32'd1);
      end
      case (mode)
        0:       ready_in = 1'b1;
        1:       ready_in = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: ready_in = 1'($urandom_range(0, 1));
      endcase
      if (poke && cyc == 3) begin
        req_line    = 1'b1;
        point_start = 24'($urandom);
      end
      if (poke && cyc == 4) begin
        chk({tag, " req while busy"}, 32'(ack_line), 32'd0);
        req_line = 1'b0;
      end
      if (valid_out && ready_in) begin
        got_q.push_back(point_out);
        chk($sformatf("%s point %0d", tag, idx), 32'(point_out), 32'(exp_q[idx]));
        chk($sformatf("%s eoc %0d", tag, idx), 32'(eoc), 32'(idx == exp_q.size() - 1));
        idx++;
        if (eoc || idx >= exp_q.size()) fin = 1'b1;
      end
      held     = valid_out && !ready_in;
      hold_pt  = point_out;
      hold_eoc = eoc;
      @(posedge clk); #1;
      cyc++;
    end
    req_line = 1'b0;
    chk({tag, " beats"}, 32'(idx), 32'(exp_q.size()));
    chk({tag, " valid after"}, 32'(valid_out), 32'd0);
    chk({tag, " eoc after"}, 32'(eoc), 32'd0);
    chk({tag, " busy after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          nbad_mono;
    int          w;
    logic [23:0] rs, re;
    rst = 1'b1; req_line = 1'b0; ready_in = 1'b0;
    point_start = '0; point_end = '0;
    #1 rst = 1'b0;
    #1;
    chk("reset ack", 32'(ack_line), 32'd0);
    chk("reset valid", 32'(valid_out), 32'd0);
    chk("reset eoc", 32'(eoc), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset point", 32'(point_out), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    vecs[0] = '{24'h000000, 24'h040008, 0, 1'b0,   5, 24'h040008};
    vecs[1] = '{24'h64C864, 24'h326432, 0, 1'b1, 101, 24'h326432};
    vecs[2] = '{24'h101010, 24'h101010, 0, 1'b0,   1, 24'h101010};
    vecs[3] = '{24'h000000, 24'h0100FF, 0, 1'b0,   2, 24'h0100FF};
    vecs[4] = '{24'h000000, 24'h040008, 1, 1'b0,   5, 24'h040008};

    for (int i = 0; i < 5; i++) begin
      run_line($sformatf("vec%0d", i), vecs[i].ps, vecs[i].pe, vecs[i].mode, vecs[i].poke);
      chk($sformatf("vec%0d count", i), 32'(got_q.size()), 32'(vecs[i].exp_n));
      if (got_q.size() > 0)
        chk($sformatf("vec%0d last", i), 32'(got_q[got_q.size() - 1]), 32'(vecs[i].exp_last));
      if (i == 0) begin
        for (int k = 0; k < got_q.size(); k++)
          chk($sformatf("horiz pt %0d", k), 32'(got_q[k]), 32'({8'(k), 8'h00, 8'(2 * k)}));
        ref_q = got_q;
      end
      if (i == 1) begin
        nbad_mono = 0;
        for (int k = 1; k < got_q.size(); k++)
          if (got_q[k][15:8] > got_q[k-1][15:8] || got_q[k][7:0] > got_q[k-1][7:0])
            nbad_mono++;
        chk("steep monotonic", 32'(nbad_mono), 32'd0);
      end
      if (i == 3 && got_q.size() > 0)
        chk("large z first", 32'(got_q[0]), 32'h000000);
      if (i == 4) begin
        chk("bp size", 32'(got_q.size()), 32'(ref_q.size()));
        for (int k = 0; k < got_q.size() && k < ref_q.size(); k++)
          chk($sformatf("bp vs ready1 %0d", k), 32'(got_q[k]), 32'(ref_q[k]));
      end
    end

    // Reset in the middle of a line, after three accepted points.
    point_start = 24'h000000; point_end = 24'h0A0014; req_line = 1'b1;
    @(posedge clk); #1;
    req_line = 1'b0; ready_in = 1'b1;
    w = 0;
    while (!valid_out && w < 40) begin @(posedge clk); #1; w++; end
    chk("mid-reset valid seen", 32'(valid_out), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid-reset point", 32'(point_out), 32'd0);
    chk("mid-reset valid", 32'(valid_out), 32'd0);
    chk("mid-reset eoc", 32'(eoc), 32'd0);
    chk("mid-reset busy", 32'(busy), 32'd0);
    chk("mid-reset ack", 32'(ack_line), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("post-reset busy", 32'(busy), 32'd0);
    run_line("after reset", 24'h050505, 24'h000000, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      rs = 24'($urandom);
      re = 24'($urandom);
      case (n % 5)
        0: re[23:16] = rs[23:16];
        1: re[15:8]  = rs[15:8];
        2: re[7:0]   = rs[7:0];
        default: ;
      endcase
      run_line($sformatf("rand%0d", n), rs, re, 2, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
